// File: rtl/bram_rd_streamer_pkg.sv
// Shared definitions for the BRAM read streamer.
// Holds the controller state encoding, the clog2 helper used for port
// widths, and the parameter legality check applied by the top level.
package bram_rd_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int rd_width, input int rd_depth,
                                        input int out_width, input int rd_latency,
                                        input int fifo_depth);
        return (out_width > 0) && (rd_width >= out_width) &&
               ((rd_width % out_width) == 0) && (rd_depth >= 2) &&
               ((rd_latency == 1) || (rd_latency == 2)) &&
               (fifo_depth >= rd_latency + 2) && is_pow2(fifo_depth);
    endfunction

endpackage

// File: rtl/bram_rd_streamer_fifo.sv
// bram_rd_fifo: first-word-fall-through prefetch FIFO for wide RAM words.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset (pointers/count only)
//   push, wdata write one word
//   pop         release the head word (caller guarantees non-empty)
//   rdata       current head word, valid whenever count != 0
//   count       number of stored words
module bram_rd_fifo
    import bram_rd_streamer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    localparam logic [PW-1:0] ONE_P = 1;
    localparam logic [CW-1:0] ONE_C = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + ONE_C;
                2'b01:   cnt <= cnt - ONE_C;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/bram_rd_streamer.sv
// bram_rd_streamer: reads a run of wide RAM words and replays them as a
// narrow valid/ready stream, least-significant slice first.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start/start_addr/num_words transfer request, sampled in IDLE only
//   busy, done                 transfer in progress / one-cycle completion pulse
//   ram_en/ram_regce/ram_addr  RAM read port control
//   ram_dout                   RAM read data, C_RD_LATENCY cycles after ram_en
//   m_valid/m_ready/m_data/m_last  output stream
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_ISSUE | issuing reads as prefetch credits allow
// ST_DRAIN | all reads issued, streaming out the remainder
// ST_DONE  | one-cycle done pulse
module bram_rd_streamer
    import bram_rd_streamer_pkg::*;
#(
    parameter int C_RAM_RD_WIDTH = 32,
    parameter int C_RAM_RD_DEPTH = 1024,
    parameter int C_OUT_WIDTH    = 16,
    parameter int C_RD_LATENCY   = 1,
    parameter int C_FIFO_DEPTH   = 4,
    localparam int AW = clog2(C_RAM_RD_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [AW-1:0]             start_addr,
    input  logic [AW:0]               num_words,
    output logic                      busy,
    output logic                      done,
    output logic                      ram_en,
    output logic                      ram_regce,
    output logic [AW-1:0]             ram_addr,
    input  logic [C_RAM_RD_WIDTH-1:0] ram_dout,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [C_OUT_WIDTH-1:0]    m_data,
    output logic                      m_last
);

    localparam int RATIO = C_RAM_RD_WIDTH / C_OUT_WIDTH;
    localparam int BW    = (RATIO > 1) ? clog2(RATIO) : 1;
    localparam int CW    = clog2(C_FIFO_DEPTH) + 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
    localparam logic [BW-1:0] ONE_B     = 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(C_RAM_RD_DEPTH - 1);
    localparam logic [AW-1:0] ONE_A     = 1;
    localparam logic [AW:0]   ONE_W     = 1;
    localparam logic [CW:0]   CREDITS   = (CW + 1)'(C_FIFO_DEPTH);

    if (!params_legal(C_RAM_RD_WIDTH, C_RAM_RD_DEPTH, C_OUT_WIDTH,
                      C_RD_LATENCY, C_FIFO_DEPTH)) begin : g_bad_params
        $error("bram_rd_streamer: illegal parameter combination");
    end

    state_t                    state;
    state_t                    state_nxt;
    logic [AW-1:0]             issue_addr;
    logic [AW:0]               issue_left;
    logic [AW:0]               words_left;
    logic [C_RD_LATENCY-1:0]   pipe_v;
    logic [BW-1:0]             beat_cnt;
    logic [CW-1:0]             in_flight;
    logic [CW-1:0]             fifo_count;
    logic [C_RAM_RD_WIDTH-1:0] fifo_rdata;
    logic [C_OUT_WIDTH-1:0]    slices [RATIO];
    logic                      credit_ok;
    logic                      push;
    logic                      pop;
    logic                      handshake;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (num_words == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (ram_en && (issue_left == ONE_W)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (handshake && m_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        ram_en = 1'b0;
        case (state)
            ST_ISSUE: begin
                busy   = 1'b1;
                ram_en = credit_ok;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // ---------------- credit / issue path ----------------
    // Every outstanding read owns a FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < C_RD_LATENCY; i++) begin
            in_flight = in_flight + CW'(pipe_v[i]);
        end
    end

    assign credit_ok = ({1'b0, in_flight} + {1'b0, fifo_count}) < CREDITS;
    assign ram_addr  = issue_addr;
    assign ram_regce = (C_RD_LATENCY == 2);
    assign push      = pipe_v[C_RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_addr <= '0;
            issue_left <= '0;
            words_left <= '0;
            pipe_v     <= '0;
            beat_cnt   <= '0;
        end else begin
            pipe_v[0] <= ram_en;
            for (int i = 1; i < C_RD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
            if ((state == ST_IDLE) && start) begin
                issue_addr <= start_addr;
                issue_left <= num_words;
                words_left <= num_words;
                beat_cnt   <= '0;
            end else begin
                if (ram_en) begin
                    issue_addr <= (issue_addr == LAST_ADDR) ? '0 : issue_addr + ONE_A;
                    issue_left <= issue_left - ONE_W;
                end
                if (handshake) begin
                    beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + ONE_B;
                    if (pop) begin
                        words_left <= words_left - ONE_W;
                    end
                end
            end
        end
    end

    bram_rd_fifo #(
        .WIDTH (C_RAM_RD_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (ram_dout),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    // ---------------- serializer ----------------
    always_comb begin
        for (int i = 0; i < RATIO; i++) begin
            slices[i] = fifo_rdata[i*C_OUT_WIDTH +: C_OUT_WIDTH];
        end
    end

    assign m_valid   = (fifo_count != '0);
    assign handshake = m_valid && m_ready;
    assign pop       = handshake && (beat_cnt == LAST_BEAT);
    // Gate data so the bus reads zero rather than stale FIFO contents when idle.
    assign m_data    = m_valid ? slices[beat_cnt] : '0;
    assign m_last    = m_valid && (beat_cnt == LAST_BEAT) && (words_left == ONE_W);

endmodule

// File: tb/tb_bram_rd_streamer.sv
module tb_bram_rd_streamer;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int NI    = 2;   // instance g uses read latency g+1

    typedef enum int {M_IDLE, M_BUSY, M_DONE} mst_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   num_words  = '0;
    logic          m_ready    = 1'b0;

    logic          busy      [NI];
    logic          done      [NI];
    logic          ram_en    [NI];
    logic          ram_regce [NI];
    logic [AW-1:0] ram_addr  [NI];
    logic [31:0]   ram_dout  [NI];
    logic          m_valid   [NI];
    logic [15:0]   m_data    [NI];
    logic          m_last    [NI];

    logic [31:0] salt = '0;
    int          n_pass  = 0;
    int          n_total = 0;
    bit          mon_en     = 1'b0;
    bit          all_ready  = 1'b0;
    bit          ready_rand = 1'b0;

    // reference model state, owned by the monitor
    mst_t          st [NI] = '{M_IDLE, M_IDLE};
    int            cyc        [NI];
    int            beats      [NI];
    int            issued     [NI];
    int            popped     [NI];
    bit            seen_valid [NI];
    bit            prev_stall [NI];
    bit            just_rst   [NI];
    logic [15:0]   prev_data  [NI];
    logic [16:0]   exp_q  [NI][$];
    logic [AW-1:0] addr_q [NI][$];
    logic [16:0]   mon_e;
    logic [AW-1:0] mon_a;
    logic [31:0]   mon_w;
    bit            mon_last_hs;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(2 * int'(a));
        hi = 16'(2 * int'(a) + 1);
        return {hi, lo} ^ salt;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [31:0] q1;
        logic [31:0] q2;

        bram_rd_streamer #(
            .C_RAM_RD_WIDTH (32),
            .C_RAM_RD_DEPTH (DEPTH),
            .C_OUT_WIDTH    (16),
            .C_RD_LATENCY   (g + 1),
            .C_FIFO_DEPTH   (4)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start),
            .start_addr (start_addr),
            .num_words  (num_words),
            .busy       (busy[g]),
            .done       (done[g]),
            .ram_en     (ram_en[g]),
            .ram_regce  (ram_regce[g]),
            .ram_addr   (ram_addr[g]),
            .ram_dout   (ram_dout[g]),
            .m_valid    (m_valid[g]),
            .m_ready    (m_ready),
            .m_data     (m_data[g]),
            .m_last     (m_last[g])
        );

        always @(posedge clk) begin
            if (ram_en[g]) q1 <= ram_word(ram_addr[g]);
            if (ram_regce[g]) q2 <= q1;
        end
        assign ram_dout[g] = (g == 0) ? q1 : q2;
    end

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)",
                      name, g, act, exp, $time);
    endtask

    // Monitor: compares every cycle against the model, then advances the model.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < NI; g++) begin
                mon_last_hs = 1'b0;
                if (st[g] != M_IDLE) cyc[g]++;
                chk("busy", g, 32'(busy[g]), 32'(st[g] == M_BUSY));
                chk("done", g, 32'(done[g]), 32'(st[g] == M_DONE));
                if (just_rst[g]) chk("ram_addr_after_reset", g, 32'(ram_addr[g]), 32'd0);
                if (st[g] != M_BUSY) begin
                    chk("ram_en_idle", g, 32'(ram_en[g]), 32'd0);
                    chk("m_valid_idle", g, 32'(m_valid[g]), 32'd0);
                    chk("m_data_idle", g, 32'(m_data[g]), 32'd0);
                    chk("m_last_idle", g, 32'(m_last[g]), 32'd0);
                    prev_stall[g] = 1'b0;
                end else begin
                    if (ram_en[g]) begin
                        issued[g]++;
                        if (addr_q[g].size() == 0)
                            chk("ram_en_extra", g, 32'(ram_en[g]), 32'd0);
                        else
                            chk("ram_addr", g, 32'(ram_addr[g]), 32'(addr_q[g].pop_front()));
                        chk("credit_bound", g, 32'((issued[g] - popped[g]) <= 4), 32'd1);
                    end
                    if (prev_stall[g]) begin
                        chk("stall_valid", g, 32'(m_valid[g]), 32'd1);
                        chk("stall_data", g, 32'(m_data[g]), 32'(prev_data[g]));
                    end
                    if (all_ready && seen_valid[g])
                        chk("no_bubble", g, 32'(m_valid[g]), 32'd1);
                    if (m_valid[g]) begin
                        if (!seen_valid[g]) begin
                            seen_valid[g] = 1'b1;
                            chk("first_valid_cycle", g, 32'(cyc[g]), 32'(3 + g));
                        end
                        if (exp_q[g].size() == 0) begin
                            chk("beat_extra", g, 32'(m_valid[g]), 32'd0);
                        end else begin
                            mon_e = exp_q[g][0];
                            chk("m_data", g, 32'(m_data[g]), 32'(mon_e[15:0]));
                            chk("m_last", g, 32'(m_last[g]), 32'(mon_e[16]));
                            if (m_ready) begin
                                void'(exp_q[g].pop_front());
                                beats[g]++;
                                if ((beats[g] % 2) == 0) popped[g]++;
                                mon_last_hs = mon_e[16];
                            end
                        end
                    end
                    prev_stall[g] = m_valid[g] && !m_ready;
                    prev_data[g]  = m_data[g];
                end

                just_rst[g] = 1'b0;
                if (!rst_n) begin
                    st[g] = M_IDLE;
                    exp_q[g].delete();
                    addr_q[g].delete();
                    just_rst[g]   = 1'b1;
                    prev_stall[g] = 1'b0;
                end else begin
                    case (st[g])
                        M_IDLE: if (start) begin
                            cyc[g] = 0; beats[g] = 0; issued[g] = 0; popped[g] = 0;
                            seen_valid[g] = 1'b0;
                            for (int i = 0; i < int'(num_words); i++) begin
                                mon_a = AW'((int'(start_addr) + i) % DEPTH);
                                mon_w = ram_word(mon_a);
                                addr_q[g].push_back(mon_a);
                                exp_q[g].push_back({1'b0, mon_w[15:0]});
                                exp_q[g].push_back({(i == int'(num_words) - 1), mon_w[31:16]});
                            end
                            st[g] = (num_words == '0) ? M_DONE : M_BUSY;
                        end
                        M_BUSY: if (mon_last_hs) st[g] = M_DONE;
                        default: st[g] = M_IDLE;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic launch(input int sa, input int n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = AW'(sa);
        num_words  = (AW + 1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((st[0] != M_IDLE || st[1] != M_IDLE) && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_after_transfer", 0, 32'(busy[0]), 32'd0);
        chk("idle_after_transfer", 1, 32'(busy[1]), 32'd0);
    endtask

    task automatic run_xfer(input int sa, input int n);
        launch(sa, n);
        wait_idle();
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        all_ready = 1'b1;

        // basic in-order stream, then address wrap, then empty transfer
        salt = '0;
        run_xfer(0, 8);
        run_xfer(1022, 4);
        run_xfer(0, 0);

        // start pulsed while busy must be ignored
        launch(100, 10);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; start_addr = AW'(500); num_words = (AW + 1)'(3);
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // randomized back-pressure
        all_ready  = 1'b0;
        ready_rand = 1'b1;
        salt = $urandom;
        run_xfer(int'($urandom_range(0, DEPTH - 1)), 64);
        repeat (6) begin
            salt = $urandom;
            run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)));
        end
        ready_rand = 1'b0;
        @(posedge clk);
        #1 all_ready = 1'b1;

        // reset in the middle of a transfer, then a clean transfer
        salt = 32'h0000_a5a5;
        launch(200, 16);
        k = 0;
        while (beats[0] < 5 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        salt = '0;
        run_xfer(0, 8);

        for (int g = 0; g < NI; g++) begin
            chk("beats_left_over", g, 32'(exp_q[g].size()), 32'd0);
            chk("reads_left_over", g, 32'(addr_q[g].size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
